// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch/ID/ctrl signal bundle for the instruction prefetch queue
interface inst_fetch_queue_if #(
  parameter int AW = 2
);
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        if_ce_i;
  logic [31:0] if_pc_i;
  logic [31:0] if_inst_i;
  logic        branch_flag_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        fetch_stall_req_o;
  logic [AW:0] count_o;

  modport master (
    output stall_i, flush_i, if_ce_i, if_pc_i, if_inst_i, branch_flag_i,
    input  id_pc_o, id_inst_o, fetch_stall_req_o, count_o
  );

  modport slave (
    input  stall_i, flush_i, if_ce_i, if_pc_i, if_inst_i, branch_flag_i,
    output id_pc_o, id_inst_o, fetch_stall_req_o, count_o
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction prefetch queue replacing the IF/ID pipeline register
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic             clk,
  input logic             rst,
  inst_fetch_queue_if.slave bus
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;

  logic accept;
  logic adv;
  logic bubble;
  logic take_branch;
  logic empty;
  logic full;
  logic pop;
  logic bypass;
  logic push;

  // Stall bits 5:3 belong to later stages and do not affect this queue.
  logic unused_stall_bits;
  assign unused_stall_bits = ^bus.stall_i[5:3];

  // Per-cycle decisions: capture, advance, bypass, push and pop.
  always_comb begin
    accept      = bus.if_ce_i & ~bus.stall_i[0];
    adv         = ~bus.stall_i[1];
    bubble      = bus.stall_i[1] & ~bus.stall_i[2];
    take_branch = bus.branch_flag_i & adv;
    empty       = (count == '0);
    full        = (count == FULL_COUNT);
    pop         = ~bus.flush_i & ~take_branch & adv & ~empty;
    bypass      = ~bus.flush_i & ~take_branch & adv & empty & accept;
    // A full queue only takes a new entry when one leaves in the same cycle.
    push        = ~bus.flush_i & ~take_branch & accept & ~bypass & (~full | pop);
  end

  // Pointer and occupancy bookkeeping; flush and taken branch empty the queue.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i || take_branch) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; written only when a fetch is actually queued.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= bus.if_pc_i;
      inst_mem[wr_ptr] <= bus.if_inst_i;
    end
  end

  // ID register: a taken branch selects the same source as a normal advance
  // (head, else the incoming fetch, else a nop); only the queue handling differs.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      id_pc   <= '0;
      id_inst <= '0;
    end else if (adv) begin
      if (!empty) begin
        id_pc   <= pc_mem[rd_ptr];
        id_inst <= inst_mem[rd_ptr];
      end else if (accept) begin
        id_pc   <= bus.if_pc_i;
        id_inst <= bus.if_inst_i;
      end else begin
        id_pc   <= '0;
        id_inst <= '0;
      end
    end else if (bubble) begin
      id_pc   <= '0;
      id_inst <= '0;
    end
  end

  assign bus.id_pc_o           = id_pc;
  assign bus.id_inst_o         = id_inst;
  assign bus.count_o           = count;
  assign bus.fetch_stall_req_o = full & ~take_branch;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall_drv;

  always #5 clk = ~clk;

  inst_fetch_queue_if #(.AW(AW)) bus ();

  // ctrl folds the queue's stall request into the PC-hold bit
  assign bus.stall_i = {stall_drv[5:1], stall_drv[0] | bus.fetch_stall_req_o};

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t        mq[$];
  logic [31:0] m_pc   = '0;
  logic [31:0] m_inst = '0;

  logic        lit_on     = 1'b0;
  logic [31:0] lit_pc     = '0;
  logic [31:0] lit_inst   = '0;
  logic [31:0] lit_cnt    = '0;
  logic        lit_req_on = 1'b0;
  logic        lit_req    = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // compare DUT against model (and any literal pins) mid-cycle
  always @(negedge clk) begin
    logic exp_req;
    exp_req = (mq.size() == DEPTH) && !(bus.branch_flag_i && !stall_drv[1]);
    chk("id_pc", bus.id_pc_o, m_pc);
    chk("id_inst", bus.id_inst_o, m_inst);
    chk("count", {29'b0, bus.count_o}, 32'(mq.size()));
    chk("fetch_stall_req", {31'b0, bus.fetch_stall_req_o}, {31'b0, exp_req});
    if (lit_on) begin
      chk("lit_id_pc", bus.id_pc_o, lit_pc);
      chk("lit_id_inst", bus.id_inst_o, lit_inst);
      chk("lit_count", {29'b0, bus.count_o}, lit_cnt);
    end
    if (lit_req_on)
      chk("lit_stall_req", {31'b0, bus.fetch_stall_req_o}, {31'b0, lit_req});
  end

  task automatic cyc(input logic rs, input logic fl, input logic ce,
                     input logic [31:0] pc, input logic [31:0] ins,
                     input logic [5:0] st, input logic br,
                     input logic creq, input logic ereq,
                     input logic ck, input logic [31:0] epc,
                     input logic [31:0] eins, input logic [31:0] ecnt);
    logic mreq, acc, adv, bub;
    ent_t inc, h;
    rst               = rs;
    bus.flush_i       = fl;
    bus.if_ce_i       = ce;
    bus.if_pc_i       = pc;
    bus.if_inst_i     = ins;
    stall_drv         = st;
    bus.branch_flag_i = br;
    lit_req_on        = creq;
    lit_req           = ereq;
    mreq = (mq.size() == DEPTH) && !(br && !st[1]);
    acc  = ce && !(st[0] || mreq);
    adv  = !st[1];
    bub  = st[1] && !st[2];
    inc  = {pc, ins};
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
      m_pc   = '0;
      m_inst = '0;
    end else if (adv) begin
      if (mq.size() > 0) begin
        h      = mq.pop_front();
        m_pc   = h.pc;
        m_inst = h.inst;
        if (!br && acc) mq.push_back(inc);
      end else if (acc) begin
        m_pc   = pc;
        m_inst = ins;
      end else begin
        m_pc   = '0;
        m_inst = '0;
      end
      if (br) mq.delete();
    end else begin
      if (bub) begin
        m_pc   = '0;
        m_inst = '0;
      end
      if (acc) mq.push_back(inc);
    end
    lit_on   = ck;
    lit_pc   = epc;
    lit_inst = eins;
    lit_cnt  = ecnt;
    #1;
  endtask

  localparam logic [5:0] HOLD = 6'b000110;
  localparam logic [5:0] BUB  = 6'b000010;
  localparam logic [5:0] RUN  = 6'b000000;

  initial begin
    logic [5:0] st_tbl [9];
    st_tbl = '{6'd6, 6'd6, 6'd6, 6'd0, 6'd7, 6'd6, 6'd2, 6'd0, 6'd6};

    // reset, first cycle without chip-enable, then bypass stream
    cyc(1, 0, 0, 32'h0,  32'h0,         RUN, 0, 0, 0, 1, 32'h0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0,  32'h0,         RUN, 0, 1, 0, 1, 32'h0, 32'h0, 0);
    cyc(0, 0, 1, 32'h0,  32'hAAAA_0001, RUN, 0, 1, 0, 1, 32'h0, 32'hAAAA_0001, 0);
    cyc(0, 0, 1, 32'h4,  32'hAAAA_0002, RUN, 0, 0, 0, 1, 32'h4, 32'hAAAA_0002, 0);
    cyc(0, 0, 1, 32'h8,  32'hAAAA_0003, RUN, 0, 0, 0, 1, 32'h8, 32'hAAAA_0003, 0);
    // fill while ID/EX held
    cyc(0, 0, 1, 32'h10, 32'hD000_0010, HOLD, 0, 1, 0, 1, 32'h8, 32'hAAAA_0003, 1);
    cyc(0, 0, 1, 32'h14, 32'hD000_0014, HOLD, 0, 1, 0, 1, 32'h8, 32'hAAAA_0003, 2);
    cyc(0, 0, 1, 32'h18, 32'hD000_0018, HOLD, 0, 1, 0, 1, 32'h8, 32'hAAAA_0003, 3);
    cyc(0, 0, 1, 32'h1C, 32'hD000_001C, HOLD, 0, 1, 0, 1, 32'h8, 32'hAAAA_0003, 4);
    cyc(0, 0, 1, 32'h20, 32'hE000_0020, HOLD, 0, 1, 1, 1, 32'h8, 32'hAAAA_0003, 4);
    // release and drain in order
    cyc(0, 0, 1, 32'h20, 32'hE000_0020, RUN, 0, 1, 1, 1, 32'h10, 32'hD000_0010, 3);
    cyc(0, 0, 0, 32'h0,  32'h0,         RUN, 0, 1, 0, 1, 32'h14, 32'hD000_0014, 2);
    cyc(0, 0, 0, 32'h0,  32'h0,         RUN, 0, 0, 0, 1, 32'h18, 32'hD000_0018, 1);
    cyc(0, 0, 0, 32'h0,  32'h0,         RUN, 0, 0, 0, 1, 32'h1C, 32'hD000_001C, 0);
    cyc(0, 0, 0, 32'h0,  32'h0,         RUN, 0, 0, 0, 1, 32'h0, 32'h0, 0);
    // branch with three queued entries keeps only the delay slot
    cyc(0, 0, 1, 32'h20, 32'hF000_0020, HOLD, 0, 0, 0, 1, 32'h0, 32'h0, 1);
    cyc(0, 0, 1, 32'h24, 32'hF000_0024, HOLD, 0, 0, 0, 1, 32'h0, 32'h0, 2);
    cyc(0, 0, 1, 32'h28, 32'hF000_0028, HOLD, 0, 0, 0, 1, 32'h0, 32'h0, 3);
    cyc(0, 0, 1, 32'h2C, 32'hF000_002C, RUN, 1, 1, 0, 1, 32'h20, 32'hF000_0020, 0);
    cyc(0, 0, 1, 32'h100, 32'h7000_0100, RUN, 0, 0, 0, 1, 32'h100, 32'h7000_0100, 0);
    // branch on empty queue: incoming fetch is the delay slot
    cyc(0, 0, 1, 32'h40, 32'h6000_0040, RUN, 1, 0, 0, 1, 32'h40, 32'h6000_0040, 0);
    cyc(0, 0, 1, 32'h200, 32'h7000_0200, RUN, 0, 0, 0, 1, 32'h200, 32'h7000_0200, 0);
    cyc(0, 0, 0, 32'h0,  32'h0,         RUN, 1, 0, 0, 1, 32'h0, 32'h0, 0);
    // branch while full: stall request drops that cycle
    cyc(0, 0, 1, 32'h300, 32'h8000_0300, HOLD, 0, 0, 0, 1, 32'h0, 32'h0, 1);
    cyc(0, 0, 1, 32'h304, 32'h8000_0304, HOLD, 0, 0, 0, 1, 32'h0, 32'h0, 2);
    cyc(0, 0, 1, 32'h308, 32'h8000_0308, HOLD, 0, 0, 0, 1, 32'h0, 32'h0, 3);
    cyc(0, 0, 1, 32'h30C, 32'h8000_030C, HOLD, 0, 0, 0, 1, 32'h0, 32'h0, 4);
    cyc(0, 0, 1, 32'h310, 32'h8000_0310, RUN, 1, 1, 0, 1, 32'h300, 32'h8000_0300, 0);
    // bubble inserts a nop but still queues the fetch
    cyc(0, 0, 1, 32'h400, 32'h9000_0400, BUB, 0, 0, 0, 1, 32'h0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0,   32'h0,         RUN, 0, 0, 0, 1, 32'h400, 32'h9000_0400, 0);
    // flush with two queued
    cyc(0, 0, 1, 32'h500, 32'hB000_0500, HOLD, 0, 0, 0, 1, 32'h400, 32'h9000_0400, 1);
    cyc(0, 0, 1, 32'h504, 32'hB000_0504, HOLD, 0, 0, 0, 1, 32'h400, 32'h9000_0400, 2);
    cyc(0, 1, 1, 32'h508, 32'hB000_0508, RUN, 0, 0, 0, 1, 32'h0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0,   32'h0,         RUN, 0, 0, 0, 1, 32'h0, 32'h0, 0);
    // reset with three queued
    cyc(0, 0, 1, 32'h5F0, 32'hC000_05F0, RUN, 0, 0, 0, 1, 32'h5F0, 32'hC000_05F0, 0);
    cyc(0, 0, 1, 32'h600, 32'hC000_0600, HOLD, 0, 0, 0, 1, 32'h5F0, 32'hC000_05F0, 1);
    cyc(0, 0, 1, 32'h604, 32'hC000_0604, HOLD, 0, 0, 0, 1, 32'h5F0, 32'hC000_05F0, 2);
    cyc(0, 0, 1, 32'h608, 32'hC000_0608, HOLD, 0, 0, 0, 1, 32'h5F0, 32'hC000_05F0, 3);
    cyc(1, 0, 1, 32'h60C, 32'hC000_060C, RUN, 0, 0, 0, 1, 32'h0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0,   32'h0,         RUN, 0, 1, 0, 1, 32'h0, 32'h0, 0);

    // deterministic mixed pattern: wraparound, concurrent push/pop, branches
    for (int i = 0; i < 90; i++) begin
      cyc(0, 0, (i % 5) != 3, 32'h1000 + 32'(4 * i), 32'h5000_0000 + 32'(i),
          st_tbl[i % 9], (i % 11) == 10, 0, 0, 0, 32'h0, 32'h0, 0);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
